// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-limited arbiter sharing one FIFO write port between several producers.
// Optional macro FIFO_WRITE_ARBITER_LOCK_EN adds request_lock to keep multi-beat packets contiguous.
module fifo_write_arbiter #(
  parameter int REQUESTERS      = 4,
  parameter int WIDTH           = 8,
  parameter int MAX_BURST       = 4,
  parameter int REQUESTERS_LOG2 = $clog2(REQUESTERS),
  parameter int BURST_LOG2      = $clog2(MAX_BURST + 1)
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic [REQUESTERS-1:0]         request_valid,
  input  logic [REQUESTERS*WIDTH-1:0]   request_data,
  output logic [REQUESTERS-1:0]         request_ready,
`ifdef FIFO_WRITE_ARBITER_LOCK_EN
  input  logic [REQUESTERS-1:0]         request_lock,
`endif
  input  logic                          fifo_write_full,
  output logic                          fifo_write_enable,
  output logic [WIDTH-1:0]              fifo_write_data,
  output logic                          grant_active,
  output logic [REQUESTERS_LOG2-1:0]    grant_index
);

  // state   | meaning
  // IDLE    | no owner; arbitrate on any request_valid
  // GRANTED | grant_index owns the write port until burst end or valid drop
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_GRANTED = 1'b1;

  logic [0:0]                 state, state_next;
  logic [REQUESTERS_LOG2-1:0] owner_next;
  logic [REQUESTERS_LOG2-1:0] pointer, pointer_next;
  logic [BURST_LOG2-1:0]      count, count_next;
  logic [REQUESTERS_LOG2-1:0] arb_start;
  logic [REQUESTERS_LOG2:0]   arb_result;
  logic                       arb_found;
  logic [REQUESTERS_LOG2-1:0] arb_lane;
  logic                       owner_valid;
  logic                       owner_lock;
  logic                       transfer;
  logic                       burst_end;
  logic                       release_grant;

  function automatic logic [REQUESTERS_LOG2-1:0] next_lane(input logic [REQUESTERS_LOG2-1:0] lane);
    return (lane == REQUESTERS_LOG2'(REQUESTERS - 1)) ? '0 : lane + REQUESTERS_LOG2'(1);
  endfunction

  // Returns {found, lane}; scanning high-to-low offsets leaves the nearest valid lane last.
  function automatic logic [REQUESTERS_LOG2:0] arbitrate(input logic [REQUESTERS-1:0] valid,
                                                         input logic [REQUESTERS_LOG2-1:0] start);
    logic [REQUESTERS_LOG2:0] result;
    int idx;
    result = '0;
    for (int i = REQUESTERS - 1; i >= 0; i--) begin
      idx = (int'(start) + i) % REQUESTERS;
      if (valid[idx]) result = {1'b1, REQUESTERS_LOG2'(idx)};
    end
    return result;
  endfunction

  assign grant_active = (state == ST_GRANTED);
  assign owner_valid  = request_valid[grant_index];

`ifdef FIFO_WRITE_ARBITER_LOCK_EN
  assign owner_lock = request_lock[grant_index];
`else
  assign owner_lock = 1'b0;
`endif

  assign fifo_write_data   = request_data[int'(grant_index)*WIDTH +: WIDTH];
  assign fifo_write_enable = resetn && grant_active && owner_valid && !fifo_write_full;
  assign transfer          = fifo_write_enable;

  always_comb begin
    request_ready = '0;
    if (resetn && grant_active && !fifo_write_full) request_ready[grant_index] = 1'b1;
  end

  assign burst_end     = transfer && (count == BURST_LOG2'(MAX_BURST - 1)) && !owner_lock;
  assign release_grant = burst_end || (!owner_valid && !owner_lock);

  assign arb_start  = (state == ST_IDLE) ? pointer : next_lane(grant_index);
  assign arb_result = arbitrate(request_valid, arb_start);
  assign arb_found  = arb_result[REQUESTERS_LOG2];
  assign arb_lane   = arb_result[REQUESTERS_LOG2-1:0];

  always_comb begin
    state_next   = state;
    owner_next   = grant_index;
    pointer_next = pointer;
    count_next   = count;
    case (state)
      ST_IDLE: begin
        if (arb_found) begin
          state_next   = ST_GRANTED;
          owner_next   = arb_lane;
          pointer_next = next_lane(arb_lane);
          count_next   = '0;
        end
      end
      default: begin
        if (release_grant) begin
          count_next = '0;
          if (arb_found) begin
            owner_next   = arb_lane;
            pointer_next = next_lane(arb_lane);
          end else begin
            state_next = ST_IDLE;
          end
        end else if (owner_lock) begin
          count_next = '0;
        end else if (transfer) begin
          count_next = count + BURST_LOG2'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      grant_index <= '0;
      pointer     <= '0;
      count       <= '0;
    end else begin
      state       <= state_next;
      grant_index <= owner_next;
      pointer     <= pointer_next;
      count       <= count_next;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus randomized traffic against a rule-level model.
// Exercises request_lock when FIFO_WRITE_ARBITER_LOCK_EN is defined.
module tb_fifo_write_arbiter;
  localparam int R  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic           clock = 1'b0;
  logic           resetn;
  logic [R-1:0]   valid;
  logic [R*W-1:0] data;
  logic [R-1:0]   ready;
  logic [R-1:0]   lock;
  logic           full;
  logic           wr_en;
  logic [W-1:0]   wr_data;
  logic           active;
  logic [1:0]     index;

  int tests = 0;
  int fails = 0;
  int wr_lanes[$];

  // Reference model: who owns the port, beats done in this grant, and next scan start.
  bit m_active;
  int m_owner;
  int m_beats;
  int m_ptr;

  fifo_write_arbiter #(.REQUESTERS(R), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clock(clock),
    .resetn(resetn),
    .request_valid(valid),
    .request_data(data),
    .request_ready(ready),
`ifdef FIFO_WRITE_ARBITER_LOCK_EN
    .request_lock(lock),
`endif
    .fifo_write_full(full),
    .fifo_write_enable(wr_en),
    .fifo_write_data(wr_data),
    .grant_active(active),
    .grant_index(index)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [R-1:0] v, input int start);
    for (int k = 0; k < R; k++)
      if (v[(start + k) % R]) return (start + k) % R;
    return -1;
  endfunction

  function automatic bit lock_of(input int lane);
`ifdef FIFO_WRITE_ARBITER_LOCK_EN
    return lock[lane];
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_active = 0; m_owner = 0; m_beats = 0; m_ptr = 0;
  endtask

  task automatic model_clock();
    bit xfer, locked, done;
    int w;
    if (!resetn) begin
      model_reset();
    end else if (!m_active) begin
      w = pick(valid, m_ptr);
      if (w >= 0) begin
        m_active = 1; m_owner = w; m_beats = 0; m_ptr = (w + 1) % R;
      end
    end else begin
      xfer   = valid[m_owner] && !full;
      locked = lock_of(m_owner);
      done   = !locked && ((xfer && m_beats + 1 == MB) || !valid[m_owner]);
      if (done) begin
        w = pick(valid, (m_owner + 1) % R);
        m_beats = 0;
        if (w >= 0) begin
          m_owner = w; m_ptr = (w + 1) % R;
        end else begin
          m_active = 0;
        end
      end else if (locked) begin
        m_beats = 0;
      end else if (xfer) begin
        m_beats++;
      end
    end
  endtask

  // Inputs are already driven; check outputs, log writes, then advance one clock.
  task automatic step();
    bit          exp_en;
    logic [R-1:0] exp_ready;
    #1;
    exp_en    = resetn && m_active && valid[m_owner] && !full;
    exp_ready = (resetn && m_active && !full) ? R'(1 << m_owner) : '0;
    check("grant_active", 32'(active), 32'(m_active));
    check("grant_index", 32'(index), 32'(m_owner));
    check("write_enable", 32'(wr_en), 32'(exp_en));
    check("request_ready", 32'(ready), 32'(exp_ready));
    check("write_data", 32'(wr_data), 32'(data[m_owner*W +: W]));
    if (wr_en) wr_lanes.push_back(int'(index));
    @(posedge clock);
    model_clock();
    @(negedge clock);
  endtask

  task automatic do_reset();
    resetn = 1'b0; valid = '0; full = 1'b0; lock = '0;
    step();
    resetn = 1'b1;
    wr_lanes.delete();
  endtask

  initial begin
    resetn = 1'b0; valid = '0; data = '0; full = 1'b0; lock = '0;
    model_reset();
    @(posedge clock);
    @(negedge clock);

    // Reset state
    do_reset();
    #1;
    check("reset_active", 32'(active), 32'd0);
    check("reset_index", 32'(index), 32'd0);
    check("reset_enable", 32'(wr_en), 32'd0);

    // Single lane 2 with data 0x5A
    data = 32'h11_5A_22_33;
    valid = 4'b0100;
    step();
    #1;
    check("t1_active", 32'(active), 32'd1);
    check("t1_index", 32'(index), 32'd2);
    check("t1_enable", 32'(wr_en), 32'd1);
    check("t1_data", 32'(wr_data), 32'h5A);
    check("t1_ready", 32'(ready), 32'b0100);
    step();
    valid = '0;
    step();

    // All lanes valid: 4 beats each in lane order, no bubbles
    do_reset();
    valid = 4'hF;
    for (int c = 0; c < 33; c++) begin
      data = $urandom;
      step();
    end
    check("rr_count", 32'(wr_lanes.size()), 32'd32);
    for (int k = 0; k < 32 && k < wr_lanes.size(); k++)
      check("rr_lane", 32'(wr_lanes[k]), 32'((k / 4) % 4));

    // Only lane 1 valid for 10 beats
    do_reset();
    valid = 4'b0010;
    for (int c = 0; c < 11; c++) begin
      data = $urandom;
      step();
    end
    valid = '0;
    step();
    check("solo_count", 32'(wr_lanes.size()), 32'd10);
    foreach (wr_lanes[k]) check("solo_lane", 32'(wr_lanes[k]), 32'd1);
    #1;
    check("solo_idle", 32'(active), 32'd0);

    // Full for 5 cycles after 2 beats of lane 0
    do_reset();
    valid = 4'b0011;
    for (int c = 0; c < 3; c++) step();
    full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("full_enable", 32'(wr_en), 32'd0);
      check("full_ready", 32'(ready), 32'd0);
      check("full_hold", 32'(index), 32'd0);
      step();
    end
    full = 1'b0;
    for (int c = 0; c < 3; c++) step();
    check("full_count", 32'(wr_lanes.size()), 32'd5);
    for (int k = 0; k < 4 && k < wr_lanes.size(); k++)
      check("full_lane0", 32'(wr_lanes[k]), 32'd0);
    if (wr_lanes.size() >= 5) check("full_next", 32'(wr_lanes[4]), 32'd1);

    // Reset mid-burst with lane 3 owner
    do_reset();
    valid = 4'b1000;
    for (int c = 0; c < 3; c++) step();
    check("mid_owner", 32'(index), 32'd3);
    valid = 4'hF;
    resetn = 1'b0;
    #1;
    check("mid_rst_enable", 32'(wr_en), 32'd0);
    step();
    resetn = 1'b1;
    #1;
    check("mid_after_active", 32'(active), 32'd0);
    check("mid_after_enable", 32'(wr_en), 32'd0);
    step();
    #1;
    check("mid_next_owner", 32'(index), 32'd0);
    check("mid_next_active", 32'(active), 32'd1);

`ifdef FIFO_WRITE_ARBITER_LOCK_EN
    // Locked lane 1 keeps the port for 7 beats
    do_reset();
    valid = 4'b0010;
    lock  = 4'b0010;
    step();
    valid = 4'b0111;
    for (int c = 0; c < 7; c++) step();
    valid = 4'b0101;
    lock  = 4'b0000;
    step();
    check("lock_count", 32'(wr_lanes.size()), 32'd7);
    foreach (wr_lanes[k]) check("lock_lane", 32'(wr_lanes[k]), 32'd1);
    #1;
    check("lock_next", 32'(index), 32'd2);
    check("lock_active", 32'(active), 32'd1);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int l = 0; l < R; l++) begin
        if ($urandom_range(0, 3) == 0) valid[l] = ~valid[l];
        if ($urandom_range(0, 7) == 0) lock[l] = ~lock[l];
      end
      data   = $urandom;
      full   = ($urandom_range(0, 3) == 0);
      resetn = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single write port of a FIFO (synchronous or asynchronous FIFO controller, write side) between REQUESTERS independent producers.
- Registered round-robin grant with a per-grant burst limit, so one producer cannot starve the others.
- Zero-latency datapath from the granted lane to the FIFO; one cycle of arbitration latency from idle.
- Sits in the FIFO write clock domain, directly in front of write_enable/write_data/write_full.

Parameters:
REQUESTERS, 4, number of producer lanes (>=2)
WIDTH, 8, data width per lane and of the FIFO write port
MAX_BURST, 4, maximum consecutive transfers per grant (>=1)
REQUESTERS_LOG2, CLOG2(REQUESTERS), width of grant_index
BURST_LOG2, CLOG2(MAX_BURST+1), width of the internal beat counter

Ports:
clock  input  1  clock; all logic on rising edge
resetn  input  1  synchronous active-low reset
request_valid  input  REQUESTERS  per-lane data valid
request_data  input  REQUESTERS*WIDTH  lane i at bits [i*WIDTH +: WIDTH]
request_ready  output  REQUESTERS  per-lane ready; a transfer occurs on valid&ready
fifo_write_full  input  1  FIFO full flag
fifo_write_enable  output  1  FIFO write strobe
fifo_write_data  output  WIDTH  FIFO write data
grant_active  output  1  a lane currently owns the port
grant_index  output  REQUESTERS_LOG2  current owner lane

Behaviour:
- Reset (resetn low at a clock edge):
  - state=IDLE, grant_index=0, grant_active=0, beat counter=0, round-robin pointer=0.
  - Outputs during reset: request_ready=0, fifo_write_enable=0.
- Combinational datapath:
  - fifo_write_data = request_data lane grant_index, always, including when idle.
  - request_ready[i] = grant_active && grant_index==i && !fifo_write_full.
  - fifo_write_enable = grant_active && request_valid[grant_index] && !fifo_write_full.
- Arbitration function:
  - Selects the first set bit of request_valid, scanning upward from pointer with wrap-around.
  - The pointer is set to owner+1 (mod REQUESTERS) whenever a grant is issued.
- States:
  - IDLE:
    - grant_active=0; no transfers.
    - If any request_valid, go to GRANTED next edge with the arbitrated owner and counter=0.
  - GRANTED, counter increments on each transfer. Release condition:
    - (a) transfer && counter==MAX_BURST-1, or
    - (b) !request_valid[owner].
  - On release, re-arbitrate in the same cycle on the current request_valid, using pointer=owner+1:
    - any valid: stay GRANTED with the new owner, counter=0;
    - else: go to IDLE.
  - On (a), the releasing owner may win again only if no other lane is valid.
- FIFO full:
  - No transfer, counter holds, grant holds while owner valid.
  - Full never causes release by itself.
- Protocol: producers must hold valid and data stable until ready; a valid dropped without a transfer is a requester protocol violation (not checked).
- MAX_BURST=1: release after every transfer; back-to-back transfers to different lanes with no idle cycle.
- Throughput: one transfer per cycle sustained while any lane is valid and the FIFO is not full, except the single IDLE->GRANTED cycle.
- Reset mid-burst: next cycle in IDLE, pointer=0; any transfer in the reset cycle is not performed.

Optional Feature:
FIFO_WRITE_ARBITER_LOCK_EN
- With the macro:
  - Adds port request_lock, input, REQUESTERS wide.
  - While request_lock[owner]=1, release (a) is suppressed and the counter holds at 0.
  - Release happens only via (b) with lock low, or via (a) once lock deasserts; the counter restarts from 0 when lock drops.
  - Lock on a non-owner lane has no effect.
  - Used for multi-beat packets that must stay contiguous in the FIFO.
- Without the macro: port absent; burst limit always enforced.

Test Plan:
- Reset, then lane 2 valid with data 0x5A, FIFO not full:
  - cycle 1 grant_active=1, grant_index=2;
  - cycle 1 fifo_write_enable=1 with data 0x5A, request_ready[2]=1.
- All 4 lanes continuously valid, MAX_BURST=4, never full:
  - FIFO receives 4 beats from lane 0, then 4 from lane 1, then lane 2, then lane 3, repeating;
  - no idle cycles after the first grant.
- Only lane 1 valid for 10 beats, MAX_BURST=4:
  - 10 consecutive writes, all from lane 1 (re-grant after every 4);
  - then IDLE once valid drops.
- Lane 0 granted, fifo_write_full held high 5 cycles mid-burst after 2 beats:
  - fifo_write_enable=0 and request_ready=0 for those 5 cycles, grant held;
  - exactly 2 further beats after full drops, then release.
- Reset asserted mid-burst (lane 3 owner, counter=2):
  - next cycle grant_active=0, fifo_write_enable=0;
  - with all lanes valid, next grant is lane 0.
- LOCK_EN build: lane 1 lock=1 with 7 valid beats, other lanes valid:
  - 7 contiguous lane-1 writes;
  - lane 2 granted immediately after lock and valid drop.
